// File: rtl/sccb_master_ctrl.sv
// SCCB master sequencer: one 3-phase write, or a 2-phase write followed by a
// 2-phase read, per accepted request, timed from the divider's sccb_clk/mid_pulse.
module sccb_master_ctrl #(
  parameter int unsigned GAP_PERIODS = 1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       sccb_clk,
  input  logic       mid_pulse,
  input  logic       start,
  input  logic       rd,
  input  logic [6:0] id,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic       sio_c,
  output logic       sio_d_out,
  output logic       sio_d_oe,
  input  logic       sio_d_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       ack_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_START_A, S_START_B, S_BITS, S_STOP_A, S_STOP_B, S_GAP
  } state_e;

  state_e      state_q, state_d;
  logic        sccb_clk_q;
  logic        sin_q1, sin_q2;
  logic        follow_q, follow_d;
  logic        sio_d_q, sio_d_d;
  logic        oe_q, oe_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        ack_err_q, ack_err_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [7:0]  shift_q, shift_d;
  logic [6:0]  id_q, id_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        rd_q, rd_d;
  logic        second_q, second_d;
  logic [1:0]  ph_q, ph_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] gap_q, gap_d;

  logic        rise;
  logic [1:0]  ph_nxt, last_ph;
  logic [7:0]  byte_cur, byte_nxt;
  logic        rdph_cur, rdph_nxt;

  // Returns {oe, d} for bit position cnt (0 = MSB, 8 = ACK/NA slot).
  function automatic logic [1:0] bit_drive(input logic rd_ph, input logic [7:0] byte_v,
                                           input logic [3:0] cnt);
    logic [7:0] sh;
    sh = byte_v << cnt[2:0];
    if (cnt == 4'd8) return rd_ph ? 2'b11 : 2'b01;
    else             return rd_ph ? 2'b01 : {1'b1, sh[7]};
  endfunction

  assign rise     = sccb_clk & ~sccb_clk_q;
  assign ph_nxt   = ph_q + 2'd1;
  assign last_ph  = rd_q ? 2'd1 : 2'd2;
  assign byte_cur = (ph_q == 2'd0) ? {id_q, second_q} : (ph_q == 2'd1) ? addr_q : wdata_q;
  assign byte_nxt = (ph_nxt == 2'd1) ? addr_q : wdata_q;
  assign rdph_cur = rd_q & second_q & (ph_q == 2'd1);
  assign rdph_nxt = rd_q & second_q & (ph_nxt == 2'd1);

  always_comb begin
    state_d   = state_q;
    follow_d  = follow_q;
    sio_d_d   = sio_d_q;
    oe_d      = oe_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ack_err_d = ack_err_q;
    rdata_d   = rdata_q;
    shift_d   = shift_q;
    id_d      = id_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_d      = rd_q;
    second_d  = second_q;
    ph_d      = ph_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    unique case (state_q)
      S_IDLE: begin
        follow_d = 1'b0;
        sio_d_d  = 1'b1;
        oe_d     = 1'b1;
        if (start) begin
          id_d      = id;
          addr_d    = addr;
          wdata_d   = wdata;
          rd_d      = rd;
          busy_d    = 1'b1;
          ack_err_d = 1'b0;
          second_d  = 1'b0;
          ph_d      = 2'd0;
          cnt_d     = 4'd0;
          state_d   = S_START_A;
        end
      end
      S_START_A: if (mid_pulse) begin
        sio_d_d = 1'b0;
        oe_d    = 1'b1;
        state_d = S_START_B;
      end
      S_START_B: if (mid_pulse) begin
        follow_d        = 1'b1;
        cnt_d           = 4'd0;
        {oe_d, sio_d_d} = bit_drive(rdph_cur, byte_cur, 4'd0);
        state_d         = S_BITS;
      end
      S_BITS: begin
        if (rise) begin
          if (cnt_q == 4'd8) begin
            if (!rdph_cur) ack_err_d = ack_err_q | sin_q2;
          end else if (rdph_cur) begin
            shift_d = {shift_q[6:0], sin_q2};
          end
        end
        if (mid_pulse) begin
          if (cnt_q == 4'd8) begin
            if (ph_q == last_ph) begin
              oe_d    = 1'b1;
              sio_d_d = 1'b0;
              state_d = S_STOP_A;
            end else begin
              ph_d            = ph_nxt;
              cnt_d           = 4'd0;
              {oe_d, sio_d_d} = bit_drive(rdph_nxt, byte_nxt, 4'd0);
            end
          end else begin
            cnt_d           = cnt_q + 4'd1;
            {oe_d, sio_d_d} = bit_drive(rdph_cur, byte_cur, cnt_q + 4'd1);
          end
        end
      end
      S_STOP_A: if (rise) begin
        follow_d = 1'b0;
        state_d  = S_STOP_B;
      end
      S_STOP_B: if (mid_pulse) begin
        sio_d_d = 1'b1;
        if (rd_q && !second_q) begin
          second_d = 1'b1;
          gap_d    = '0;
          state_d  = S_GAP;
        end else begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          if (rd_q) rdata_d = shift_q;
          state_d = S_IDLE;
        end
      end
      S_GAP: if (mid_pulse) begin
        if (32'(gap_q) + 32'd1 >= GAP_PERIODS) begin
          ph_d    = 2'd0;
          cnt_d   = 4'd0;
          state_d = S_START_A;
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      sccb_clk_q <= 1'b0;
      sin_q1     <= 1'b1;
      sin_q2     <= 1'b1;
      follow_q   <= 1'b0;
      sio_d_q    <= 1'b1;
      oe_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ack_err_q  <= 1'b0;
      rdata_q    <= '0;
      shift_q    <= '0;
      id_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= 1'b0;
      second_q   <= 1'b0;
      ph_q       <= '0;
      cnt_q      <= '0;
      gap_q      <= '0;
    end else begin
      state_q    <= state_d;
      sccb_clk_q <= sccb_clk;
      sin_q1     <= sio_d_in;
      sin_q2     <= sin_q1;
      follow_q   <= follow_d;
      sio_d_q    <= sio_d_d;
      oe_q       <= oe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ack_err_q  <= ack_err_d;
      rdata_q    <= rdata_d;
      shift_q    <= shift_d;
      id_q       <= id_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      second_q   <= second_d;
      ph_q       <= ph_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
    end
  end

  // SIO_C tracks the divider clock only between the start and stop conditions.
  assign sio_c     = follow_q ? sccb_clk : 1'b1;
  assign sio_d_out = sio_d_q;
  assign sio_d_oe  = oe_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign ack_err   = ack_err_q;

endmodule

// File: tb/tb_sccb_master_ctrl.sv
// Directed bench for sccb_master_ctrl: 10 MHz clk, /100 SCCB divider, a bus
// monitor that decodes frames, and a responder that ACKs and returns read data.
module tb_sccb_master_ctrl;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic       rd = 1'b0;
  logic [6:0] id = '0;
  logic [7:0] addr = '0;
  logic [7:0] wdata = '0;
  logic       sccb_clk, mid_pulse;
  logic       sio_c, sio_d_out, sio_d_oe, sio_d_in;
  logic       busy, done, ack_err;
  logic [7:0] rdata;

  int unsigned div = 0;
  longint      cyc = 0;
  int          tests = 0;
  int          fails = 0;

  always #50 clk = ~clk;
  always @(posedge clk) begin
    div <= (div == 99) ? 0 : div + 1;
    cyc <= cyc + 1;
  end
  assign sccb_clk  = (div >= 50);
  assign mid_pulse = (div == 25);

  logic resp_en = 1'b0;
  logic resp_val = 1'b1;
  logic line;
  assign line     = sio_d_oe ? sio_d_out : (resp_en ? resp_val : 1'b1);
  assign sio_d_in = line;

  sccb_master_ctrl #(.GAP_PERIODS(1)) dut (
    .clk(clk), .resetn(resetn), .sccb_clk(sccb_clk), .mid_pulse(mid_pulse),
    .start(start), .rd(rd), .id(id), .addr(addr), .wdata(wdata),
    .sio_c(sio_c), .sio_d_out(sio_d_out), .sio_d_oe(sio_d_oe), .sio_d_in(sio_d_in),
    .busy(busy), .done(done), .rdata(rdata), .ack_err(ack_err)
  );

  // Bus monitor and responder state.
  logic       prev_c = 1'b1, prev_d = 1'b1;
  logic       in_frame = 1'b0, rw = 1'b0, lead_pending = 1'b0;
  logic       ack_mode = 1'b1;
  logic [7:0] rd_byte = 8'h00;
  logic [7:0] shreg = '0;
  logic [7:0] blog [0:7];
  logic       ablog [0:7];
  int         bitn = 0, bif = 0, nb = 0, nstart = 0, nstop = 0, viol = 0;
  longint     t_start = 0, min_lead = 1000000;

  always @(negedge clk) begin
    if (prev_c && sio_c && prev_d != line) begin
      if (!line && !in_frame) begin
        in_frame = 1'b1; nstart++; bitn = 0; bif = 0; rw = 1'b0;
        t_start = cyc; lead_pending = 1'b1;
      end else if (line && in_frame) begin
        in_frame = 1'b0; nstop++; bitn = 0; resp_en = 1'b0;
      end else begin
        viol++;
      end
    end else if (!prev_c && sio_c) begin
      if (in_frame) begin
        if (bitn < 8) shreg = {shreg[6:0], line};
        if (bitn == 8) begin
          if (nb < 8) begin blog[nb] = shreg; ablog[nb] = line; end
          nb++; bif++;
          if (bif == 1) rw = shreg[0];
          bitn = 0;
        end else begin
          bitn++;
        end
      end
    end else if (prev_c && !sio_c && in_frame) begin
      if (lead_pending) begin
        lead_pending = 1'b0;
        if (cyc - t_start < min_lead) min_lead = cyc - t_start;
      end
      resp_en = 1'b0;
      if (rw && bif == 1) begin
        if (bitn < 8) begin resp_en = 1'b1; resp_val = rd_byte[7 - bitn]; end
      end else if (bitn == 8 && ack_mode) begin
        resp_en = 1'b1; resp_val = 1'b0;
      end
    end
    prev_c = sio_c;
    prev_d = line;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    @(posedge clk);
    nb = 0; nstart = 0; nstop = 0; viol = 0; in_frame = 1'b0;
    bitn = 0; bif = 0; rw = 1'b0; resp_en = 1'b0; min_lead = 1000000;
  endtask

  task automatic run_txn(input logic r, input logic [6:0] i, input logic [7:0] a,
                         input logic [7:0] w, input bit restart, output int ndone);
    clear_mon();
    @(negedge clk); rd = r; id = i; addr = a; wdata = w; start = 1'b1;
    @(negedge clk); start = 1'b0;
    if (restart) begin
      repeat (300) @(negedge clk);
      check("ack_err_cleared_on_start", ack_err, 0);
      check("busy_mid_txn", busy, 1);
      rd = ~r; id = ~i; addr = ~a; wdata = ~w; start = 1'b1;
      @(negedge clk); start = 1'b0;
    end
    ndone = 0;
    for (int k = 0; k < 12000 && ndone == 0; k++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        check("busy_low_at_done", busy, 0);
      end
    end
    check("done_seen", ndone, 1);
    repeat (400) begin
      @(negedge clk);
      if (done) ndone++;
    end
  endtask

  initial begin
    int nd;
    int found;
    repeat (3) @(negedge clk);
    check("rst_sio_c", sio_c, 1);
    check("rst_sio_d_out", sio_d_out, 1);
    check("rst_sio_d_oe", sio_d_oe, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rdata", rdata, 0);
    check("rst_ack_err", ack_err, 0);
    resetn = 1'b1;
    repeat (5) @(negedge clk);

    // Write 0x21/0x12/0x80 with ACKs.
    ack_mode = 1'b1;
    run_txn(1'b0, 7'h21, 8'h12, 8'h80, 1'b0, nd);
    check("wr_one_done", nd, 1);
    check("wr_nbytes", nb, 3);
    check("wr_byte0", blog[0], 8'h42);
    check("wr_byte1", blog[1], 8'h12);
    check("wr_byte2", blog[2], 8'h80);
    check("wr_acks", {ablog[0], ablog[1], ablog[2]}, 0);
    check("wr_ack_err", ack_err, 0);
    check("wr_starts", nstart, 1);
    check("wr_stops", nstop, 1);
    check("wr_bus_viol", viol, 0);
    check("wr_start_lead_ge_period", (min_lead >= 100), 1);
    check("wr_rdata_unchanged", rdata, 0);

    // Read 0x21/0x0A, responder returns 0x76.
    rd_byte = 8'h76;
    run_txn(1'b1, 7'h21, 8'h0A, 8'h00, 1'b0, nd);
    check("rd_one_done", nd, 1);
    check("rd_nbytes", nb, 4);
    check("rd_byte0", blog[0], 8'h42);
    check("rd_byte1", blog[1], 8'h0A);
    check("rd_byte2", blog[2], 8'h43);
    check("rd_byte3_bus", blog[3], 8'h76);
    check("rd_acks", {ablog[0], ablog[1], ablog[2]}, 0);
    check("rd_na", ablog[3], 1);
    check("rd_rdata", rdata, 8'h76);
    check("rd_ack_err", ack_err, 0);
    check("rd_starts", nstart, 2);
    check("rd_stops", nstop, 2);
    check("rd_bus_viol", viol, 0);

    // Silent responder: write completes, ack_err set, rdata kept.
    ack_mode = 1'b0;
    run_txn(1'b0, 7'h3C, 8'h55, 8'hA5, 1'b0, nd);
    check("nack_one_done", nd, 1);
    check("nack_ack_err", ack_err, 1);
    check("nack_byte0", blog[0], 8'h78);
    check("nack_byte1", blog[1], 8'h55);
    check("nack_byte2", blog[2], 8'hA5);
    check("nack_rdata_kept", rdata, 8'h76);

    // Start re-pulsed while busy with different fields: ignored.
    ack_mode = 1'b1;
    run_txn(1'b0, 7'h2A, 8'h01, 8'hFE, 1'b1, nd);
    check("busy_one_done", nd, 1);
    check("busy_nbytes", nb, 3);
    check("busy_byte0", blog[0], 8'h54);
    check("busy_byte1", blog[1], 8'h01);
    check("busy_byte2", blog[2], 8'hFE);
    check("busy_ack_err", ack_err, 0);
    check("busy_starts", nstart, 1);
    check("busy_rdata_kept", rdata, 8'h76);

    // Reset asserted during the addr phase.
    clear_mon();
    @(negedge clk); rd = 1'b0; id = 7'h21; addr = 8'h33; wdata = 8'h44; start = 1'b1;
    @(negedge clk); start = 1'b0;
    found = 0;
    for (int k = 0; k < 6000 && found == 0; k++) begin
      @(negedge clk);
      if (nb == 1 && bitn >= 3) found = 1;
    end
    check("addr_phase_reached", found, 1);
    #10 resetn = 1'b0;
    #1;
    check("abort_sio_c", sio_c, 1);
    check("abort_sio_d_out", sio_d_out, 1);
    check("abort_sio_d_oe", sio_d_oe, 1);
    check("abort_busy", busy, 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    run_txn(1'b0, 7'h21, 8'h12, 8'h80, 1'b0, nd);
    check("post_rst_one_done", nd, 1);
    check("post_rst_nbytes", nb, 3);
    check("post_rst_byte0", blog[0], 8'h42);
    check("post_rst_byte1", blog[1], 8'h12);
    check("post_rst_byte2", blog[2], 8'h80);
    check("post_rst_ack_err", ack_err, 0);
    check("post_rst_bus_viol", viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
